uart_tx_packet_arbiter: RTL

//  Shares the single UART TX byte stream among NUM_SRC 16-byte packet producers:
//  TL response bridge, ADC stream, debug status.

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/uart_tx_packet_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX packet arbiter.
package uart_arb_pkg;

  localparam int unsigned PKT_BYTES_DEF = 16;
  localparam int unsigned PKT_W         = 8 * PKT_BYTES_DEF;
  localparam int unsigned IDX_W         = 3;
  localparam int unsigned SRC_TAG_LSB   = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after 'last', circularly.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Lowest requester above 'last' wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) > last)) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (req[i] && (IDX_W'(i) <= last)) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    any     = hi_found | lo_found;
    gnt_idx = hi_found ? hi_idx : lo_idx;
    gnt     = any ? (NUM_SRC'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_packet_arbiter.sv
// Round-robin arbiter that latches one packet at a time from NUM_SRC producers
// and serializes it byte 0 first onto a valid/ready byte stream for the UART TX.
// Optional build macro: UART_ARB_SRC_TAG_EN overwrites byte 0 bits 7:5 with the
// granted source index.
module uart_tx_packet_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 3,
  parameter int unsigned PKT_BYTES = PKT_BYTES_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_ready,
  input  logic [NUM_SRC*8*PKT_BYTES-1:0] src_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [7:0]                     tx_byte,
  output logic                           busy,
  output logic [IDX_W-1:0]               grant_idx
);

  localparam int unsigned PKT_WIDTH = 8 * PKT_BYTES;
  localparam int unsigned CNT_W     = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

  state_t                 state;
  state_t                 state_nxt;
  logic [PKT_WIDTH-1:0]   buffer;
  logic [PKT_WIDTH-1:0]   sel_data;
  logic [CNT_W-1:0]       byte_cnt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [NUM_SRC-1:0]     gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   any;
  logic                   last_beat;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_arbiter (
    .req     (src_valid),
    .last    (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign last_beat = tx_ready && (byte_cnt == CNT_W'(PKT_BYTES - 1));

  // Select the granted packet, optionally stamping the source id into byte 0.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel_data = src_data[i*PKT_WIDTH +: PKT_WIDTH];
      end
    end
`ifdef UART_ARB_SRC_TAG_EN
    sel_data[SRC_TAG_LSB +: IDX_W] = gnt_idx;
`else
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, leave SEND on the final accepted beat.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any)       state_nxt = ST_SEND;
      ST_SEND: if (last_beat) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: accept strobe only in IDLE, byte stream only in SEND.
  always_comb begin
    src_ready = '0;
    tx_valid  = 1'b0;
    busy      = 1'b0;
    tx_byte   = 8'h00;
    if (state == ST_IDLE) begin
      src_ready = gnt;
    end else begin
      tx_valid = 1'b1;
      busy     = 1'b1;
      tx_byte  = buffer[7:0];
    end
  end

  // Packet buffer, beat counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      buffer    <= '0;
      byte_cnt  <= '0;
      rr_ptr    <= IDX_W'(NUM_SRC - 1);
      grant_idx <= '0;
    end else if ((state == ST_IDLE) && any) begin
      buffer    <= sel_data;
      byte_cnt  <= '0;
      rr_ptr    <= gnt_idx;
      grant_idx <= gnt_idx;
    end else if ((state == ST_SEND) && tx_ready) begin
      buffer    <= buffer >> 8;
      byte_cnt  <= byte_cnt + CNT_W'(1);
    end
  end

endmodule
